// File: rtl/issue_select_pkg.sv
// Shared types and helpers for the issue-queue select stage.
// The entry layout is one packed struct, so field slices live in exactly one place.
package issue_select_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_LOG2  = 5;
    localparam int NUM_SLOTS = 8;
    localparam int SLOT_LOG2 = 3;
    localparam int ENTRY_W   = 32;
    localparam int CNT_W     = 32;

    // One queue entry, MSB first. Bits [4:0] hold rs and bits [31:19] are opaque payload.
    typedef struct packed {
        logic [12:0]         payload;
        logic                is_mem;
        logic                reg_write;
        logic                rt_vld;
        logic                rs_vld;
        logic [REG_LOG2-1:0] rd;
        logic [REG_LOG2-1:0] rt;
        logic [REG_LOG2-1:0] rs;
    } iq_entry_t;

    // An entry that writes r0 never creates a dependency.
    function automatic logic writes_reg(input iq_entry_t e);
        return e.reg_write && (e.rd != '0);
    endfunction

    function automatic logic reads_reg(input iq_entry_t e, input logic [REG_LOG2-1:0] r);
        return (e.rs_vld && (e.rs == r)) || (e.rt_vld && (e.rt == r));
    endfunction

    // Lane 1 may not pair with lane 0 on RAW, on two mem ops, or on the same destination.
    function automatic logic lane1_blocked(input iq_entry_t a, input iq_entry_t b);
        logic raw;
        logic two_mem;
        logic waw;
        raw     = writes_reg(a) && reads_reg(b, a.rd);
        two_mem = a.is_mem && b.is_mem;
        waw     = writes_reg(a) && writes_reg(b) && (a.rd == b.rd);
        return raw || two_mem || waw;
    endfunction

endpackage

// File: rtl/issue_select_scoreboard.sv
// Register busy scoreboard. Two set ports (issue), two clear ports (writeback).
// busy_byp is the busy vector with this cycle's writeback clears already applied,
// so a consumer sees its producer's writeback in the same cycle.
module issue_select_scoreboard
    import issue_select_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                set0_vld,
    input  logic [REG_LOG2-1:0] set0_reg,
    input  logic                set1_vld,
    input  logic [REG_LOG2-1:0] set1_reg,
    input  logic                clr0_vld,
    input  logic [REG_LOG2-1:0] clr0_reg,
    input  logic                clr1_vld,
    input  logic [REG_LOG2-1:0] clr1_reg,
    output logic [NUM_REGS-1:0] busy_byp
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Decode set/clear ports into one-hot masks; r0 is never tracked.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set0_vld) set_mask[set0_reg] = 1'b1;
        if (set1_vld) set_mask[set1_reg] = 1'b1;
        if (clr0_vld) clr_mask[clr0_reg] = 1'b1;
        if (clr1_vld) clr_mask[clr1_reg] = 1'b1;
        set_mask[0] = 1'b0;
        clr_mask[0] = 1'b0;
    end

    // Busy state: flush wipes everything, otherwise set wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    assign busy_byp = busy & ~clr_mask;

endmodule

// File: rtl/issue_select.sv
// Wakeup/select for the 8-entry age-ordered issue queue: picks up to two oldest
// ready entries, pops them, registers them into two issue lanes and retires
// already-popped head slots.
//
// Handshake: the issue lanes present iss*_vld/iss*_data; a lane pair is consumed
// on any rising edge where ex_ready=1. While iss0_vld=1 and ex_ready=0 both lanes
// hold and no new select or pop is made. pop* is a same-cycle request to the queue.
module issue_select
    import issue_select_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [NUM_SLOTS*ENTRY_W-1:0] slot_data,
    input  logic [NUM_SLOTS-1:0]         slot_vld,
    input  logic [3:0]                   free,
    output logic                         pop0,
    output logic                         pop1,
    output logic [SLOT_LOG2-1:0]         pop_key0,
    output logic [SLOT_LOG2-1:0]         pop_key1,
    output logic                         retire0,
    output logic                         retire1,
    input  logic                         wb0_vld,
    input  logic                         wb1_vld,
    input  logic [REG_LOG2-1:0]          wb0_reg,
    input  logic [REG_LOG2-1:0]          wb1_reg,
    input  logic                         ex_ready,
    output logic                         iss0_vld,
    output logic                         iss1_vld,
    output logic [ENTRY_W-1:0]           iss0_data,
    output logic [ENTRY_W-1:0]           iss1_data,
    output logic [CNT_W-1:0]             issued_cnt
);

    iq_entry_t             ent [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  rdy;
    logic [NUM_REGS-1:0]   busy_byp;
    logic [3:0]            occ;
    logic                  stall;
    logic                  can_sel;
    logic                  sel0;
    logic                  sel1;
    logic                  found1;
    logic [SLOT_LOG2-1:0]  key0;
    logic [SLOT_LOG2-1:0]  key1;

    assign occ     = 4'd8 - free;
    assign stall   = iss0_vld & ~ex_ready;
    assign can_sel = rst_n & ~flush & ~stall;

    issue_select_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .set0_vld (pop0 & writes_reg(ent[key0])),
        .set0_reg (ent[key0].rd),
        .set1_vld (pop1 & writes_reg(ent[key1])),
        .set1_reg (ent[key1].rd),
        .clr0_vld (wb0_vld),
        .clr0_reg (wb0_reg),
        .clr1_vld (wb1_vld),
        .clr1_reg (wb1_reg),
        .busy_byp (busy_byp)
    );

    // Unpack slots and compute operand readiness against the bypassed busy vector.
    always_comb begin
        for (int j = 0; j < NUM_SLOTS; j++) begin
            ent[j] = iq_entry_t'(slot_data[j*ENTRY_W +: ENTRY_W]);
            rdy[j] = slot_vld[j]
                   & ~(ent[j].rs_vld & busy_byp[ent[j].rs])
                   & ~(ent[j].rt_vld & busy_byp[ent[j].rt]);
        end
    end

    // Priority select: oldest ready to lane 0, the next ready one to lane 1 if it pairs.
    always_comb begin
        sel0   = 1'b0;
        found1 = 1'b0;
        key0   = '0;
        key1   = '0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if (rdy[j]) begin
                if (!sel0) begin
                    sel0 = 1'b1;
                    key0 = SLOT_LOG2'(j);
                end else if (!found1) begin
                    found1 = 1'b1;
                    key1   = SLOT_LOG2'(j);
                end
            end
        end
        sel1 = found1 & ~lane1_blocked(ent[key0], ent[key1]);
        if (!can_sel) begin
            sel0 = 1'b0;
            sel1 = 1'b0;
        end
    end

    assign pop0     = sel0;
    assign pop1     = sel1;
    assign pop_key0 = key0;
    assign pop_key1 = key1;

    // In-order head retire. A slot popped this cycle still has slot_vld=1, so it
    // can never be retired in the same cycle.
    always_comb begin
        retire0 = rst_n & ~flush & (occ >= 4'd1) & ~slot_vld[0];
        retire1 = retire0 & (occ >= 4'd2) & ~slot_vld[1];
    end

    // Issue lanes: load on every non-stalled edge, invalidate on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss0_vld  <= 1'b0;
            iss1_vld  <= 1'b0;
            iss0_data <= '0;
            iss1_data <= '0;
        end else if (flush) begin
            iss0_vld <= 1'b0;
            iss1_vld <= 1'b0;
        end else if (!stall) begin
            iss0_vld <= sel0;
            iss1_vld <= sel1;
            if (sel0) iss0_data <= ent[key0];
            if (sel1) iss1_data <= ent[key1];
        end
    end

    // Running count of issued instructions; pops are already zero on flush edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt <= '0;
        end else if (!flush) begin
            issued_cnt <= issued_cnt + CNT_W'(pop0) + CNT_W'(pop1);
        end
    end

endmodule

// File: tb/tb_issue_select.sv
// Bench for issue_select: reset checks, a table of single-cycle select vectors,
// hand-written multi-cycle sequences and a randomized run against a reference model.
module tb_issue_select;
    import issue_select_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         flush = 1'b0;
    iq_entry_t                    slot_e [NUM_SLOTS];
    logic [NUM_SLOTS*ENTRY_W-1:0] slot_data;
    logic [NUM_SLOTS-1:0]         slot_vld = '0;
    logic [3:0]                   free = 4'd8;
    logic                         wb0_vld = 1'b0;
    logic                         wb1_vld = 1'b0;
    logic [REG_LOG2-1:0]          wb0_reg = '0;
    logic [REG_LOG2-1:0]          wb1_reg = '0;
    logic                         ex_ready = 1'b1;
    logic                         pop0, pop1, retire0, retire1;
    logic [SLOT_LOG2-1:0]         pop_key0, pop_key1;
    logic                         iss0_vld, iss1_vld;
    logic [ENTRY_W-1:0]           iss0_data, iss1_data;
    logic [CNT_W-1:0]             issued_cnt;

    always #5 clk = ~clk;

    always_comb begin
        slot_data = '0;
        for (int j = 0; j < NUM_SLOTS; j++) slot_data[j*ENTRY_W +: ENTRY_W] = slot_e[j];
    end

    issue_select dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .slot_data(slot_data), .slot_vld(slot_vld), .free(free),
        .pop0(pop0), .pop1(pop1), .pop_key0(pop_key0), .pop_key1(pop_key1),
        .retire0(retire0), .retire1(retire1),
        .wb0_vld(wb0_vld), .wb1_vld(wb1_vld), .wb0_reg(wb0_reg), .wb1_reg(wb1_reg),
        .ex_ready(ex_ready),
        .iss0_vld(iss0_vld), .iss1_vld(iss1_vld),
        .iss0_data(iss0_data), .iss1_data(iss1_data),
        .issued_cnt(issued_cnt)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;
    logic [ENTRY_W-1:0] exp_q [$];

    bit              m_busy [NUM_REGS];
    logic            m_iss0_vld, m_iss1_vld;
    logic [ENTRY_W-1:0] m_iss0_data, m_iss1_data;
    logic [CNT_W-1:0]   m_cnt;
    logic            e_pop0, e_pop1, e_ret0, e_ret1;
    int              e_key0, e_key1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic iq_entry_t mk(input int rs, input bit rsv, input int rt, input bit rtv,
                                     input int rd, input bit wr, input bit mem, input int tag);
        iq_entry_t e;
        e = '0;
        e.rs = REG_LOG2'(rs); e.rs_vld = rsv;
        e.rt = REG_LOG2'(rt); e.rt_vld = rtv;
        e.rd = REG_LOG2'(rd); e.reg_write = wr;
        e.is_mem = mem; e.payload = 13'(tag);
        return e;
    endfunction

    // Pairing rule: no RAW on lane 0's destination, at most one mem op, no shared destination.
    function automatic bit pair_ok(input iq_entry_t a, input iq_entry_t b);
        bit a_w, b_w;
        a_w = a.reg_write && a.rd != 0;
        b_w = b.reg_write && b.rd != 0;
        if (a_w && ((b.rs_vld && b.rs == a.rd) || (b.rt_vld && b.rt == a.rd))) return 0;
        if (a.is_mem && b.is_mem) return 0;
        if (a_w && b_w && a.rd == b.rd) return 0;
        return 1;
    endfunction

    task automatic reset_model();
        foreach (m_busy[r]) m_busy[r] = 0;
        m_iss0_vld = 0; m_iss1_vld = 0;
        m_iss0_data = '0; m_iss1_data = '0;
        m_cnt = '0;
        exp_q.delete();
    endtask

    // Expected same-cycle outputs from the current inputs and model state.
    task automatic model_comb();
        int  rdy_q [$];
        bit  eff [NUM_REGS];
        int  occ;
        bit  allowed;
        for (int r = 0; r < NUM_REGS; r++)
            eff[r] = m_busy[r] && !(wb0_vld && wb0_reg == r) && !(wb1_vld && wb1_reg == r);
        eff[0] = 0;
        for (int j = 0; j < NUM_SLOTS; j++)
            if (slot_vld[j] && !(slot_e[j].rs_vld && eff[slot_e[j].rs])
                            && !(slot_e[j].rt_vld && eff[slot_e[j].rt]))
                rdy_q.push_back(j);
        allowed = rst_n && !flush && !(m_iss0_vld && !ex_ready);
        e_pop0 = 0; e_pop1 = 0; e_key0 = 0; e_key1 = 0;
        if (allowed && rdy_q.size() >= 1) begin
            e_pop0 = 1; e_key0 = rdy_q[0];
            if (rdy_q.size() >= 2 && pair_ok(slot_e[rdy_q[0]], slot_e[rdy_q[1]])) begin
                e_pop1 = 1; e_key1 = rdy_q[1];
            end
        end
        occ = 8 - int'(free);
        e_ret0 = rst_n && !flush && occ >= 1 && !slot_vld[0];
        e_ret1 = e_ret0 && occ >= 2 && !slot_vld[1];
    endtask

    // Model state update at the rising edge.
    task automatic model_seq();
        if (!rst_n) begin
            reset_model();
            return;
        end
        if (flush) begin
            foreach (m_busy[r]) m_busy[r] = 0;
            m_iss0_vld = 0; m_iss1_vld = 0;
            return;
        end
        if (wb0_vld) m_busy[wb0_reg] = 0;
        if (wb1_vld) m_busy[wb1_reg] = 0;
        if (e_pop0 && slot_e[e_key0].reg_write) m_busy[slot_e[e_key0].rd] = 1;
        if (e_pop1 && slot_e[e_key1].reg_write) m_busy[slot_e[e_key1].rd] = 1;
        m_busy[0] = 0;
        m_cnt = m_cnt + CNT_W'(e_pop0) + CNT_W'(e_pop1);
        if (!(m_iss0_vld && !ex_ready)) begin
            m_iss0_vld = e_pop0; m_iss1_vld = e_pop1;
            if (e_pop0) m_iss0_data = slot_e[e_key0];
            if (e_pop1) m_iss1_data = slot_e[e_key1];
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge with inputs applied; checks combinational outputs.
    task automatic settle(input string tag);
        #1;
        model_comb();
        chk({tag, ":pop0"}, 32'(pop0), 32'(e_pop0));
        chk({tag, ":pop1"}, 32'(pop1), 32'(e_pop1));
        if (e_pop0) chk({tag, ":key0"}, 32'(pop_key0), 32'(e_key0));
        if (e_pop1) chk({tag, ":key1"}, 32'(pop_key1), 32'(e_key1));
        chk({tag, ":ret0"}, 32'(retire0), 32'(e_ret0));
        chk({tag, ":ret1"}, 32'(retire1), 32'(e_ret1));
    endtask

    // Clocks one edge, checks the registered outputs and returns at the next falling edge.
    task automatic advance(input string tag);
        @(posedge clk);
        model_seq();
        if (m_iss0_vld) exp_q.push_back(m_iss0_data);
        if (m_iss1_vld) exp_q.push_back(m_iss1_data);
        #1;
        chk({tag, ":iss0_vld"}, 32'(iss0_vld), 32'(m_iss0_vld));
        chk({tag, ":iss1_vld"}, 32'(iss1_vld), 32'(m_iss1_vld));
        chk({tag, ":cnt"}, issued_cnt, m_cnt);
        if (m_iss0_vld) chk({tag, ":iss0_data"}, iss0_data, exp_q.pop_front());
        if (m_iss1_vld) chk({tag, ":iss1_data"}, iss1_data, exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic clear_slots();
        for (int j = 0; j < NUM_SLOTS; j++) slot_e[j] = '0;
        slot_vld = '0;
        free = 4'd8;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        iq_entry_t  e0, e1, e2;
        logic [7:0] vld;
        logic [3:0] free;
        logic       p0;
        logic [2:0] k0;
        logic       p1;
        logic [2:0] k1;
        logic       r0, r1;
    } vec_t;

    function automatic vec_t mkv(input iq_entry_t e0, input iq_entry_t e1, input iq_entry_t e2,
                                 input logic [7:0] vld, input logic [3:0] fr,
                                 input logic p0, input int k0, input logic p1, input int k1,
                                 input logic r0, input logic r1);
        vec_t v;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.vld = vld; v.free = fr;
        v.p0 = p0; v.k0 = 3'(k0); v.p1 = p1; v.k1 = 3'(k1); v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    vec_t          vecs [12];
    iq_entry_t     z;
    logic [ENTRY_W-1:0] held;

    initial begin
        z = '0;
        for (int j = 0; j < NUM_SLOTS; j++) slot_e[j] = '0;
        reset_model();

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst:iss0_vld", 32'(iss0_vld), 0);
        chk("rst:iss1_vld", 32'(iss1_vld), 0);
        chk("rst:cnt", issued_cnt, 0);
        chk("rst:pop0", 32'(pop0), 0);
        chk("rst:retire0", 32'(retire0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // test 2: independent pair
        slot_e[0] = mk(1, 1, 0, 0, 10, 1, 0, 21);
        slot_e[1] = mk(2, 1, 0, 0, 11, 1, 0, 22);
        slot_vld = 8'b011; free = 4'd6;
        settle("t2");
        chk("t2:pop0", 32'(pop0), 1);  chk("t2:key0", 32'(pop_key0), 0);
        chk("t2:pop1", 32'(pop1), 1);  chk("t2:key1", 32'(pop_key1), 1);
        advance("t2");
        chk("t2:iss0_data", iss0_data, mk(1, 1, 0, 0, 10, 1, 0, 21));
        chk("t2:iss1_data", iss1_data, mk(2, 1, 0, 0, 11, 1, 0, 22));
        chk("t2:cnt", issued_cnt, 2);

        // test 3: RAW dependency then same-cycle wakeup
        slot_e[0] = mk(1, 1, 0, 0, 3, 1, 0, 31);
        slot_e[1] = mk(3, 1, 0, 0, 12, 1, 0, 32);
        settle("t3a");
        chk("t3a:pop0", 32'(pop0), 1); chk("t3a:pop1", 32'(pop1), 0);
        advance("t3a");
        slot_e[0] = mk(3, 1, 0, 0, 12, 1, 0, 32); slot_e[1] = z;
        slot_vld = 8'b001; free = 4'd7;
        settle("t3b");
        chk("t3b:pop0_busy", 32'(pop0), 0);
        advance("t3b");
        wb0_vld = 1'b1; wb0_reg = 5'd3;
        settle("t3c");
        chk("t3c:pop0_bypass", 32'(pop0), 1); chk("t3c:key0", 32'(pop_key0), 0);
        advance("t3c");
        wb0_vld = 1'b0;

        // test 4: oldest blocked on r7
        slot_e[0] = mk(1, 1, 0, 0, 7, 1, 0, 41);
        settle("t4a"); advance("t4a");
        slot_e[0] = mk(7, 1, 0, 0, 13, 1, 0, 42);
        slot_e[2] = mk(1, 1, 0, 0, 14, 1, 0, 43);
        slot_vld = 8'b101; free = 4'd5;
        settle("t4b");
        chk("t4b:pop0", 32'(pop0), 1); chk("t4b:key0", 32'(pop_key0), 2);
        chk("t4b:pop1", 32'(pop1), 0); chk("t4b:ret0", 32'(retire0), 0);
        advance("t4b");
        slot_vld = 8'b001;
        settle("t4c");
        chk("t4c:pop0", 32'(pop0), 0); chk("t4c:ret0", 32'(retire0), 0);
        advance("t4c");
        wb1_vld = 1'b1; wb1_reg = 5'd7;
        settle("t4d");
        chk("t4d:pop0", 32'(pop0), 1);
        advance("t4d");
        wb1_vld = 1'b0;

        // test 5: stall holds both lanes, resume same cycle
        clear_slots();
        slot_e[0] = mk(1, 1, 0, 0, 15, 1, 0, 51);
        slot_e[1] = mk(2, 1, 0, 0, 16, 1, 0, 52);
        slot_vld = 8'b011; free = 4'd6;
        settle("t5a"); advance("t5a");
        held = iss0_data;
        slot_e[0] = mk(1, 1, 0, 0, 17, 1, 0, 53);
        slot_e[1] = mk(2, 1, 0, 0, 18, 1, 0, 54);
        ex_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle("t5s");
            chk("t5s:pop0", 32'(pop0), 0); chk("t5s:pop1", 32'(pop1), 0);
            advance("t5s");
            chk("t5s:iss0_hold", iss0_data, mk(1, 1, 0, 0, 15, 1, 0, 51));
        end
        chk("t5s:held_is_first", held, mk(1, 1, 0, 0, 15, 1, 0, 51));
        ex_ready = 1'b1;
        settle("t5r");
        chk("t5r:pop0", 32'(pop0), 1); chk("t5r:key0", 32'(pop_key0), 0);
        advance("t5r");
        chk("t5r:iss0_data", iss0_data, mk(1, 1, 0, 0, 17, 1, 0, 53));

        // test 6: retire of popped heads, then flush
        clear_slots();
        slot_e[2] = mk(1, 1, 0, 0, 9, 1, 0, 61);
        slot_vld = 8'b100; free = 4'd6;
        settle("t6a");
        chk("t6a:ret0", 32'(retire0), 1); chk("t6a:ret1", 32'(retire1), 1);
        chk("t6a:key0", 32'(pop_key0), 2);
        advance("t6a");
        flush = 1'b1;
        settle("t6f");
        chk("t6f:ret0", 32'(retire0), 0); chk("t6f:ret1", 32'(retire1), 0);
        chk("t6f:pop0", 32'(pop0), 0);
        advance("t6f");
        chk("t6f:iss0_vld", 32'(iss0_vld), 0);
        flush = 1'b0;
        clear_slots();
        slot_e[0] = mk(9, 1, 0, 0, 0, 0, 0, 62);
        slot_vld = 8'b001; free = 4'd7;
        settle("t6c");
        chk("t6c:busy_cleared", 32'(pop0), 1);
        advance("t6c");

        // test 1: asynchronous reset mid-run with a lane valid and r5 busy
        slot_e[0] = mk(1, 1, 0, 0, 5, 1, 0, 71);
        settle("t1a"); advance("t1a");
        rst_n = 1'b0;
        slot_e[0] = mk(5, 1, 0, 0, 0, 0, 0, 72);
        settle("t1r");
        chk("t1r:iss0_vld_async", 32'(iss0_vld), 0);
        chk("t1r:pop0", 32'(pop0), 0);
        chk("t1r:cnt_async", issued_cnt, 0);
        advance("t1r");
        rst_n = 1'b1;
        settle("t1b");
        chk("t1b:busy5_cleared", 32'(pop0), 1);
        advance("t1b");

        // table-driven single-cycle vectors, each after a flush
        vecs[0]  = mkv(z, z, z, 8'b000, 4'd8, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mkv(mk(2,1,0,0,1,1,0,1), mk(5,1,0,0,4,1,0,2), z, 8'b011, 4'd6, 1, 0, 1, 1, 0, 0);
        vecs[2]  = mkv(mk(1,1,0,0,3,1,0,3), mk(3,1,0,0,4,1,0,4), z, 8'b011, 4'd6, 1, 0, 0, 0, 0, 0);
        vecs[3]  = mkv(mk(1,1,0,0,2,1,1,5), mk(4,1,0,0,5,1,1,6), z, 8'b011, 4'd6, 1, 0, 0, 0, 0, 0);
        vecs[4]  = mkv(mk(1,1,0,0,6,1,0,7), mk(2,1,0,0,6,1,0,8), z, 8'b011, 4'd6, 1, 0, 0, 0, 0, 0);
        vecs[5]  = mkv(mk(1,1,0,0,2,1,0,9), z, z, 8'b001, 4'd8, 1, 0, 0, 0, 0, 0);
        vecs[6]  = mkv(z, mk(1,1,2,1,3,1,0,10), mk(4,1,5,1,6,1,0,11), 8'b110, 4'd5, 1, 1, 1, 2, 1, 0);
        vecs[7]  = mkv(z, z, mk(1,1,0,0,2,1,0,12), 8'b100, 4'd5, 1, 2, 0, 0, 1, 1);
        vecs[8]  = mkv(mk(0,1,0,0,0,1,0,13), mk(0,1,0,1,0,1,0,14), z, 8'b011, 4'd6, 1, 0, 1, 1, 0, 0);
        vecs[9]  = mkv(mk(1,1,0,0,2,1,1,15), mk(3,1,0,0,4,1,1,16), mk(5,1,0,0,6,1,0,17), 8'b111, 4'd5, 1, 0, 0, 0, 0, 0);
        vecs[10] = mkv(mk(1,1,0,0,7,1,0,18), mk(2,1,7,1,8,1,0,19), z, 8'b011, 4'd6, 1, 0, 0, 0, 0, 0);
        vecs[11] = mkv(mk(1,1,0,0,7,1,0,20), mk(2,1,7,0,8,1,0,21), z, 8'b011, 4'd6, 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            clear_slots();
            slot_e[0] = vecs[i].e0; slot_e[1] = vecs[i].e1; slot_e[2] = vecs[i].e2;
            slot_vld = vecs[i].vld; free = vecs[i].free;
            flush = 1'b1;
            settle($sformatf("v%0d_fl", i)); advance($sformatf("v%0d_fl", i));
            flush = 1'b0;
            settle($sformatf("v%0d", i));
            chk($sformatf("v%0d:tbl_pop0", i), 32'(pop0), 32'(vecs[i].p0));
            chk($sformatf("v%0d:tbl_pop1", i), 32'(pop1), 32'(vecs[i].p1));
            if (vecs[i].p0) chk($sformatf("v%0d:tbl_key0", i), 32'(pop_key0), 32'(vecs[i].k0));
            if (vecs[i].p1) chk($sformatf("v%0d:tbl_key1", i), 32'(pop_key1), 32'(vecs[i].k1));
            chk($sformatf("v%0d:tbl_ret0", i), 32'(retire0), 32'(vecs[i].r0));
            chk($sformatf("v%0d:tbl_ret1", i), 32'(retire1), 32'(vecs[i].r1));
            advance($sformatf("v%0d", i));
        end

        // randomized run against the model
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < NUM_SLOTS; j++)
                slot_e[j] = mk($urandom_range(0, 7), 1'($urandom_range(0, 1)),
                               $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                               $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 3) == 0), $urandom_range(0, 8191));
            slot_vld = 8'($urandom_range(0, 255));
            free     = 4'($urandom_range(0, 8));
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            wb0_vld  = 1'($urandom_range(0, 1));
            wb0_reg  = 5'($urandom_range(0, 7));
            wb1_vld  = 1'($urandom_range(0, 1));
            wb1_reg  = 5'($urandom_range(0, 7));
            settle("rnd");
            advance("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
